// File: rtl/dbus_arbiter.sv
// Shares one downstream data-bus port among NREQ requesters; latches the winner's request until completion.
// Optional feature: define ARB_ROUND_ROBIN_EN for rotating priority (default: fixed, lowest index wins).
module dbus_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 64,
    parameter int DW   = 64,
    localparam int SW  = DW / 8,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid_i,
    input  logic [NREQ*AW-1:0]   req_addr_i,
    input  logic [NREQ*3-1:0]    req_size_i,
    input  logic [NREQ*SW-1:0]   req_strobe_i,
    input  logic [NREQ*DW-1:0]   req_data_i,
    output logic [NREQ-1:0]      resp_addr_ok_o,
    output logic [NREQ-1:0]      resp_data_ok_o,
    output logic [DW-1:0]        resp_data_o,
    output logic                 dn_valid_o,
    output logic [AW-1:0]        dn_addr_o,
    output logic [2:0]           dn_size_o,
    output logic [SW-1:0]        dn_strobe_o,
    output logic [DW-1:0]        dn_data_o,
    input  logic                 dn_addr_ok_i,
    input  logic                 dn_data_ok_i,
    input  logic [DW-1:0]        dn_data_i
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [2:0]      size_q, size_d;
    logic [SW-1:0]   strobe_q, strobe_d;
    logic [DW-1:0]   data_q, data_d;

    logic [IW-1:0]   winner;
    logic            complete;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW:0]     rrSum;
    logic [IW-1:0]   rrIdx;
    logic            rrFound;

    // First valid requester at or after the pointer, wrapping at NREQ.
    always_comb begin
        winner  = '0;
        rrSum   = '0;
        rrIdx   = '0;
        rrFound = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            rrSum = {1'b0, ptr_q} + (IW+1)'(k);
            if (rrSum >= (IW+1)'(NREQ)) begin
                rrSum = rrSum - (IW+1)'(NREQ);
            end
            rrIdx = rrSum[IW-1:0];
            if (!rrFound && req_valid_i[rrIdx]) begin
                winner  = rrIdx;
                rrFound = 1'b1;
            end
        end
    end
`else
    always_comb begin
        winner = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                winner = IW'(i);
            end
        end
    end
`endif

    // Reset gates the ok pulse so a BUSY state still visible during reset never acknowledges.
    assign complete = (state_q == BUSY) && dn_addr_ok_i && dn_data_ok_i && !reset;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        size_d   = size_q;
        strobe_d = strobe_q;
        data_d   = data_q;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d    = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req_valid_i) begin
                    state_d  = BUSY;
                    owner_d  = winner;
                    addr_d   = req_addr_i[winner*AW +: AW];
                    size_d   = req_size_i[winner*3 +: 3];
                    strobe_d = req_strobe_i[winner*SW +: SW];
                    data_d   = req_data_i[winner*DW +: DW];
                end
            end
            BUSY: begin
                if (complete) begin
                    state_d = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
                    if (owner_q == IW'(NREQ - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = owner_q + IW'(1);
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            addr_q   <= '0;
            size_q   <= '0;
            strobe_q <= '0;
            data_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            strobe_q <= strobe_d;
            data_q   <= data_d;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    always_comb begin
        resp_addr_ok_o = '0;
        resp_data_ok_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (complete && (owner_q == IW'(i))) begin
                resp_addr_ok_o[i] = 1'b1;
                resp_data_ok_o[i] = 1'b1;
            end
        end
    end

    assign dn_valid_o  = (state_q == BUSY);
    assign dn_addr_o   = addr_q;
    assign dn_size_o   = size_q;
    assign dn_strobe_o = strobe_q;
    assign dn_data_o   = data_q;
    assign resp_data_o = dn_data_i;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Scoreboard bench for dbus_arbiter: directed requests push expected ok pulses, a negedge monitor pops and compares.
module tb_dbus_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 64;
    localparam int DW   = 64;
    localparam int SW   = DW / 8;

    logic                clk;
    logic                reset;
    logic [NREQ-1:0]     reqValid;
    logic [NREQ*AW-1:0]  reqAddr;
    logic [NREQ*3-1:0]   reqSize;
    logic [NREQ*SW-1:0]  reqStrobe;
    logic [NREQ*DW-1:0]  reqData;
    logic [NREQ-1:0]     respAddrOk;
    logic [NREQ-1:0]     respDataOk;
    logic [DW-1:0]       respData;
    logic                dnValid;
    logic [AW-1:0]       dnAddr;
    logic [2:0]          dnSize;
    logic [SW-1:0]       dnStrobe;
    logic [DW-1:0]       dnData;
    logic                dnAddrOk;
    logic                dnDataOk;
    logic [DW-1:0]       dnRdata;

    int checkCount;
    int passCount;

    typedef struct packed {
        logic [NREQ-1:0] mask;
        logic [DW-1:0]   data;
    } resp_t;

    resp_t expQ[$];

    dbus_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid_i    (reqValid),
        .req_addr_i     (reqAddr),
        .req_size_i     (reqSize),
        .req_strobe_i   (reqStrobe),
        .req_data_i     (reqData),
        .resp_addr_ok_o (respAddrOk),
        .resp_data_ok_o (respDataOk),
        .resp_data_o    (respData),
        .dn_valid_o     (dnValid),
        .dn_addr_o      (dnAddr),
        .dn_size_o      (dnSize),
        .dn_strobe_o    (dnStrobe),
        .dn_data_o      (dnData),
        .dn_addr_ok_i   (dnAddrOk),
        .dn_data_ok_i   (dnDataOk),
        .dn_data_i      (dnRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int idx, input logic [AW-1:0] addr, input logic [2:0] size,
                                 input logic [SW-1:0] strobe, input logic [DW-1:0] data);
        reqAddr[idx*AW +: AW]   = addr;
        reqSize[idx*3 +: 3]     = size;
        reqStrobe[idx*SW +: SW] = strobe;
        reqData[idx*DW +: DW]   = data;
    endtask

    // Downstream completes this cycle; the scoreboard expects exactly this pulse.
    task automatic ackCycle(input logic [NREQ-1:0] mask, input logic [DW-1:0] rdata,
                            input logic [NREQ-1:0] nextValid);
        dnAddrOk = 1'b1;
        dnDataOk = 1'b1;
        dnRdata  = rdata;
        expQ.push_back('{mask: mask, data: rdata});
        tick();
        dnAddrOk = 1'b0;
        dnDataOk = 1'b0;
        reqValid = nextValid;
    endtask

    // Monitor: any ok activity must match the oldest expected response.
    always @(negedge clk) begin
        if ((respAddrOk != '0) || (respDataOk != '0)) begin
            if (expQ.size() == 0) begin
                checkCount++;
                $display("[TB] FAIL unexpected_ok: got addr_ok=%b data_ok=%b, expected none", respAddrOk, respDataOk);
            end else begin
                resp_t e;
                e = expQ.pop_front();
                checkOutput("resp_data_ok", 64'(respDataOk), 64'(e.mask));
                checkOutput("resp_addr_ok", 64'(respAddrOk), 64'(e.mask));
                checkOutput("resp_data", respData, e.data);
            end
        end
    end

    logic [1:0] grantOrder [4];

    initial begin
        checkCount = 0;
        passCount  = 0;
        reset      = 1'b1;
        reqValid   = '0;
        reqAddr    = '0;
        reqSize    = '0;
        reqStrobe  = '0;
        reqData    = '0;
        dnAddrOk   = 1'b0;
        dnDataOk   = 1'b0;
        dnRdata    = '0;
`ifdef ARB_ROUND_ROBIN_EN
        grantOrder = '{2'd0, 2'd1, 2'd0, 2'd1};
`else
        grantOrder = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
        tick();
        tick();
        checkOutput("reset_dn_valid", 64'(dnValid), 64'd0);
        checkOutput("reset_dn_addr", dnAddr, 64'd0);
        reset = 1'b0;
        tick();

        // Single read, acked two cycles after dn_valid rises.
        applyStimulus(0, 64'h8000_0010, 3'd2, 8'h00, 64'h0);
        reqValid = 2'b01;
        tick();
        checkOutput("t1_dn_valid_c1", 64'(dnValid), 64'd1);
        checkOutput("t1_dn_addr", dnAddr, 64'h8000_0010);
        checkOutput("t1_dn_size", 64'(dnSize), 64'd2);
        tick();
        checkOutput("t1_dn_valid_c2", 64'(dnValid), 64'd1);
        tick();
        checkOutput("t1_dn_valid_c3", 64'(dnValid), 64'd1);
        ackCycle(2'b01, 64'h1234, 2'b00);
        checkOutput("t1_dn_valid_after", 64'(dnValid), 64'd0);
        tick();

        // Collision: req 0 first, one idle cycle, then req 1.
        applyStimulus(0, 64'h100, 3'd3, 8'h00, 64'h0);
        applyStimulus(1, 64'h200, 3'd3, 8'h00, 64'h0);
        reqValid = 2'b11;
        tick();
        checkOutput("t2_grant0_addr", dnAddr, 64'h100);
        ackCycle(2'b01, 64'h55, 2'b10);
        checkOutput("t2_turnaround_idle", 64'(dnValid), 64'd0);
        tick();
        checkOutput("t2_grant1_valid", 64'(dnValid), 64'd1);
        checkOutput("t2_grant1_addr", dnAddr, 64'h200);
        ackCycle(2'b10, 64'h66, 2'b00);
        tick();

        // Write with an isolated addr_ok; owner's live fields change but the latched copy holds.
        applyStimulus(1, 64'h8000_0008, 3'd3, 8'hF0, 64'hAABB_CCDD_0000_0000);
        reqValid = 2'b10;
        tick();
        checkOutput("t3_dn_addr", dnAddr, 64'h8000_0008);
        checkOutput("t3_dn_strobe", 64'(dnStrobe), 64'hF0);
        dnAddrOk = 1'b1;
        applyStimulus(1, 64'hDEAD, 3'd0, 8'h0F, 64'h1111);
        tick();
        checkOutput("t3_hold_valid", 64'(dnValid), 64'd1);
        checkOutput("t3_hold_strobe", 64'(dnStrobe), 64'hF0);
        checkOutput("t3_hold_data", dnData, 64'hAABB_CCDD_0000_0000);
        checkOutput("t3_hold_addr", dnAddr, 64'h8000_0008);
        dnAddrOk = 1'b0;
        ackCycle(2'b10, 64'h0, 2'b00);
        tick();

        // Flush: owner drops req_valid mid-transaction.
        applyStimulus(0, 64'h300, 3'd3, 8'h00, 64'h0);
        reqValid = 2'b01;
        tick();
        reqValid = 2'b00;
        tick();
        checkOutput("t4_flush_valid", 64'(dnValid), 64'd1);
        ackCycle(2'b01, 64'h77, 2'b00);
        checkOutput("t4_after_valid", 64'(dnValid), 64'd0);
        tick();
        checkOutput("t4_idle_valid", 64'(dnValid), 64'd0);

        // Reset while BUSY, with downstream acking during reset: no pulse may escape.
        reqValid = 2'b01;
        tick();
        checkOutput("t5_busy_valid", 64'(dnValid), 64'd1);
        reset    = 1'b1;
        reqValid = 2'b00;
        dnAddrOk = 1'b1;
        dnDataOk = 1'b1;
        tick();
        reset    = 1'b0;
        dnAddrOk = 1'b0;
        dnDataOk = 1'b0;
        checkOutput("t5_post_reset_valid", 64'(dnValid), 64'd0);
        checkOutput("t5_post_reset_addr", dnAddr, 64'd0);
        applyStimulus(1, 64'h400, 3'd3, 8'h00, 64'h0);
        reqValid = 2'b10;
        tick();
        checkOutput("t5_regrant_addr", dnAddr, 64'h400);
        ackCycle(2'b10, 64'h88, 2'b00);
        tick();

        // Both requesters continuously valid for four transactions.
        applyStimulus(0, 64'hA000, 3'd3, 8'h00, 64'h0);
        applyStimulus(1, 64'hB000, 3'd3, 8'h00, 64'h0);
        reqValid = 2'b11;
        for (int t = 0; t < 4; t++) begin
            tick();
            checkOutput($sformatf("t6_grant%0d", t), dnAddr,
                        (grantOrder[t] == 2'd0) ? 64'hA000 : 64'hB000);
            ackCycle((grantOrder[t] == 2'd0) ? 2'b01 : 2'b10, 64'(t + 16), 2'b11);
        end
        reqValid = 2'b00;
        tick();
        tick();

        checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
